// File: rtl/serial_pkg.sv
// Shared types and helpers for the parallel-to-serial feeder path.
package serial_pkg;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  localparam int SER_WIDTH_DEFAULT = 8;

  // Counter width for indexing bits 0..w-1 of a word.
  function automatic int ser_cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// Single-entry word buffer that lets the next word wait while the current one shifts out.
module ser_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        data  <= din;
      end else if (take) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel word to MSB-first serial stream with a one-word holding buffer for gapless streaming.
//   state     | meaning
//   SER_IDLE  | no word in the shift register, bit_out idles
//   SER_SHIFT | shift register holds a word, bit_cnt = bits already consumed
module bit_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH    = SER_WIDTH_DEFAULT,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_start,
  output logic             word_done
);

  localparam int CNT_W = ser_cnt_width(WIDTH);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;
  logic             accept;
  logic             last_bit;
  logic             hold_load;
  logic             hold_take;

  assign in_ready  = !reset && !hold_valid;
  assign accept    = in_valid && in_ready;
  assign last_bit  = (state == SER_SHIFT) && (bit_cnt == CNT_W'(WIDTH - 1)) && shift_en;
  assign hold_take = last_bit && hold_valid;
  // At the word boundary an incoming word bypasses the buffer and goes straight to shreg.
  assign hold_load = accept && (state == SER_SHIFT) && !last_bit;

  ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clock (clock),
    .reset (reset),
    .load  (hold_load),
    .take  (hold_take),
    .din   (in_data),
    .valid (hold_valid),
    .data  (hold_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= SER_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        SER_IDLE: begin
          if (accept) begin
            shreg   <= in_data;
            bit_cnt <= '0;
            state   <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (last_bit) begin
            bit_cnt <= '0;
            if (hold_valid) begin
              shreg <= hold_data;
            end else if (accept) begin
              shreg <= in_data;
            end else begin
              shreg <= '0;
              state <= SER_IDLE;
            end
          end else if (shift_en) begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

  assign bit_valid  = (state == SER_SHIFT);
  assign bit_out    = bit_valid ? shreg[WIDTH-1] : IDLE_BIT;
  assign word_start = bit_valid && (bit_cnt == '0);
  assign word_done  = last_bit;

endmodule
